// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: access opcodes, FSM states, memory width
// and small decode helpers used by the FSM and the lane aligner.
package lsu_pkg;

    localparam int MEM_AWIDTH = 10;

    typedef enum logic [2:0] {
        OP_LB  = 3'd0,
        OP_LBU = 3'd1,
        OP_LH  = 3'd2,
        OP_LHU = 3'd3,
        OP_LW  = 3'd4,
        OP_SB  = 3'd5,
        OP_SH  = 3'd6,
        OP_SW  = 3'd7
    } op_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2,
        S_RESP = 2'd3
    } state_t;

    function automatic logic is_load(op_t op);
        return (op == OP_LB) || (op == OP_LBU) || (op == OP_LH) ||
               (op == OP_LHU) || (op == OP_LW);
    endfunction

    // A halfword must sit on an even byte, a word on a multiple of four.
    function automatic logic is_misaligned(op_t op, logic [1:0] off);
        logic mis;
        mis = 1'b0;
        case (op)
            OP_LH, OP_LHU, OP_SH: mis = off[0];
            OP_LW, OP_SW:         mis = (off != 2'b00);
            default:              mis = 1'b0;
        endcase
        return mis;
    endfunction

    function automatic logic [1:0] align_offset(op_t op, logic [1:0] off);
        logic [1:0] res;
        res = off;
        case (op)
            OP_LH, OP_LHU, OP_SH: res = {off[1], 1'b0};
            OP_LW, OP_SW:         res = 2'b00;
            default:              res = off;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: little-endian load extract with sign/zero extension
// and store merge of the addressed byte/halfword into a read word.
module lsu_align
    import lsu_pkg::*;
(
    input  op_t         op,
    input  logic [1:0]  offset,
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] store_word
);

    logic [7:0]  lane_byte;
    logic [15:0] lane_half;

    always_comb begin
        lane_byte = word[7:0];
        case (offset)
            2'd1:    lane_byte = word[15:8];
            2'd2:    lane_byte = word[23:16];
            2'd3:    lane_byte = word[31:24];
            default: lane_byte = word[7:0];
        endcase
        lane_half = offset[1] ? word[31:16] : word[15:0];
    end

    always_comb begin
        load_data = word;
        case (op)
            OP_LB:   load_data = {{24{lane_byte[7]}}, lane_byte};
            OP_LBU:  load_data = {24'h000000, lane_byte};
            OP_LH:   load_data = {{16{lane_half[15]}}, lane_half};
            OP_LHU:  load_data = {16'h0000, lane_half};
            default: load_data = word;
        endcase
    end

    // Partial stores keep every lane of the read word except the addressed one.
    always_comb begin
        store_word = word;
        case (op)
            OP_SB: begin
                case (offset)
                    2'd0:    store_word[7:0]   = wdata[7:0];
                    2'd1:    store_word[15:8]  = wdata[7:0];
                    2'd2:    store_word[23:16] = wdata[7:0];
                    default: store_word[31:24] = wdata[7:0];
                endcase
            end
            OP_SH: begin
                if (offset[1]) begin
                    store_word[31:16] = wdata[15:0];
                end else begin
                    store_word[15:0] = wdata[15:0];
                end
            end
            OP_SW:   store_word = wdata;
            default: store_word = word;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit FSM between a CPU port and a word-wide data memory.
// Optional LSU_MISALIGN_TRAP_EN: misaligned accesses trap with err instead of being aligned down.
module load_store_unit
    import lsu_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req,
    input  logic [2:0]            op,
    input  logic [31:0]           addr,
    input  logic [31:0]           wdata,
    output logic                  ready,
    output logic                  done,
    output logic [31:0]           rdata,
    output logic                  err,
    output logic [MEM_AWIDTH-1:0] mem_addr,
    output logic [31:0]           mem_din,
    output logic                  mem_wen,
    output logic                  mem_ren,
    input  logic [31:0]           mem_dout
);

    state_t      state;
    op_t         op_q;
    logic [1:0]  offset_q;
    logic [31:0] wdata_q;
    op_t         op_in;
    logic        trap;
    logic [1:0]  acc_off;
    logic [31:0] load_data;
    logic [31:0] store_word;
    logic        unused_addr;

    assign op_in       = op_t'(op);
    assign ready       = (state == S_IDLE);
    assign unused_addr = ^addr[31:12];

`ifdef LSU_MISALIGN_TRAP_EN
    assign trap    = is_misaligned(op_in, addr[1:0]);
    assign acc_off = addr[1:0];
`else
    assign trap    = 1'b0;
    assign acc_off = align_offset(op_in, addr[1:0]);
`endif

    lsu_align u_align (
        .op         (op_q),
        .offset     (offset_q),
        .word       (mem_dout),
        .wdata      (wdata_q),
        .load_data  (load_data),
        .store_word (store_word)
    );

    // done/err/mem_wen/mem_ren are single-cycle pulses; mem_addr only moves on accept.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            op_q     <= OP_LB;
            offset_q <= 2'b00;
            wdata_q  <= 32'h0;
            done     <= 1'b0;
            err      <= 1'b0;
            rdata    <= 32'h0;
            mem_addr <= '0;
            mem_din  <= 32'h0;
            mem_wen  <= 1'b0;
            mem_ren  <= 1'b0;
        end else begin
            done    <= 1'b0;
            err     <= 1'b0;
            mem_wen <= 1'b0;
            mem_ren <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req) begin
                        op_q     <= op_in;
                        wdata_q  <= wdata;
                        offset_q <= acc_off;
                        if (trap) begin
                            err   <= 1'b1;
                            state <= S_RESP;
                        end else if (op_in == OP_SW) begin
                            mem_addr <= addr[11:2];
                            mem_din  <= wdata;
                            mem_wen  <= 1'b1;
                            state    <= S_WR;
                        end else begin
                            mem_addr <= addr[11:2];
                            mem_ren  <= 1'b1;
                            state    <= S_RD;
                        end
                    end
                end
                S_RD: begin
                    if (is_load(op_q)) begin
                        rdata <= load_data;
                        done  <= 1'b1;
                        state <= S_RESP;
                    end else begin
                        mem_din <= store_word;
                        mem_wen <= 1'b1;
                        state   <= S_WR;
                    end
                end
                S_WR: begin
                    done  <= 1'b1;
                    state <= S_RESP;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
